mem_arb: RTL and testbench

s.
REQ-037 Store response: o_d_rdata=0 and o_d_err=0 unless the access timed out.
REQ-038 Requests dropped before their ack while still ungranted are ignored; dropping after grant is a protocol violation.
REQ-039 When no ack is asserted, o_if_rdata, o_d_rdata and both err outputs are 0.

Reset
REQ-040 i_rst=1: state goes to IDLE, wait counter to 0, last-grant to DATA (the first tie goes to fetch).
REQ-041 During and after reset, every output is 0 until the next grant.
REQ-042 Reset during BUSY or RESP abandons the access with no ack issued; the requester must re-issue it.

Structure
REQ-043 Package eric_pkg holds: the state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2), requester IDs (REQ_IF=1'b0, REQ_D=1'b1) and the alignment-mask constant.
REQ-044 The 2-way round-robin picker is a sub-module named arb_rr2 (inputs: two requests and last-grant; output: winner); all other logic stays in mem_arb.

Verification
REQ-045 Fetch only: i_if_addr=0x102 and word 0xBEEF1234 re

---
 rtl/eric_pkg.sv | 26 ++
 rtl/mem_arb_rr2.sv | 31 +++
 rtl/mem_arb.sv | 184 ++++++++++++++++++
 tb/tb_mem_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eric_pkg.sv
// -----------------------------------------------------------------------------
// eric_pkg
// Shared definitions for the memory arbiter: FSM state encoding, requester
// identifiers and the word-alignment mask used to detect misaligned data
// accesses.
// -----------------------------------------------------------------------------
package eric_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Requester identifiers; also the encoding of the last-grant register.
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    // Byte-address bits that must be zero for a 32-bit word access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return (addr_lsbs & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2
// Two-way round-robin picker. When both requesters are pending, the one that
// was not granted last wins; otherwise the only pending requester wins.
// Output is meaningless when neither request is pending.
//
// Ports
//   i_req_if  fetch request pending
//   i_req_d   data request pending
//   i_last    requester granted most recently (REQ_IF / REQ_D)
//   o_winner  requester to grant (REQ_IF / REQ_D)
// -----------------------------------------------------------------------------
module arb_rr2
    import eric_pkg::*;
(
    input  logic i_req_if,
    input  logic i_req_d,
    input  logic i_last,
    output logic o_winner
);

    always_comb begin
        o_winner = REQ_IF;
        if (i_req_if && i_req_d) begin
            o_winner = ~i_last;
        end else if (i_req_d) begin
            o_winner = REQ_D;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb
// Arbitrates an instruction-fetch port and a data port onto a single memory
// port, one access outstanding at a time (IDLE -> BUSY -> RESP -> IDLE).
// Accesses that see no i_m_ready for TIMEOUT cycles complete with an error;
// misaligned data accesses complete with an error without touching memory.
//
// Ports
//   i_clk, i_rst                clock, synchronous active-high reset
//   i_if_req/i_if_addr          fetch request; addr[1] selects the halfword
//   o_if_ack/o_if_rdata/o_if_err  fetch completion pulse, halfword, error
//   i_d_req/i_d_we/i_d_addr/i_d_wdata  data request (store when we=1)
//   o_d_ack/o_d_rdata/o_d_err   data completion pulse, load data, error
//   o_m_req/o_m_we/o_m_addr/o_m_wdata  memory access (held for whole access)
//   i_m_ready/i_m_rdata         memory completion and read data
// -----------------------------------------------------------------------------
module mem_arb
    import eric_pkg::*;
#(
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_ack,
    output logic [15:0]   o_if_rdata,
    output logic          o_if_err,
    input  logic          i_d_req,
    input  logic          i_d_we,
    input  logic [AW-1:0] i_d_addr,
    input  logic [31:0]   i_d_wdata,
    output logic          o_d_ack,
    output logic [31:0]   o_d_rdata,
    output logic          o_d_err,
    output logic          o_m_req,
    output logic          o_m_we,
    output logic [AW-1:0] o_m_addr,
    output logic [31:0]   o_m_wdata,
    input  logic          i_m_ready,
    input  logic [31:0]   i_m_rdata
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [7:0]    wait_q, wait_d;
    logic          last_q, last_d;
    logic          gnt_q, gnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          hsel_q, hsel_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic winner;
    logic any_req;
    logic busy;
    logic if_ack;
    logic d_ack;

    // Byte-lane bit 0 of a fetch address carries no information for
    // halfword fetches.
    logic unused_if_addr_b0;
    assign unused_if_addr_b0 = i_if_addr[0];

    arb_rr2 u_arb (
        .i_req_if (i_if_req),
        .i_req_d  (i_d_req),
        .i_last   (last_q),
        .o_winner (winner)
    );

    assign any_req = i_if_req | i_d_req;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        hsel_d  = hsel_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d   = winner;
                    last_d  = winner;
                    wait_d  = 8'd0;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = BUSY;
                    if (winner == REQ_D) begin
                        addr_d  = {i_d_addr[AW-1:2], 2'b00};
                        hsel_d  = 1'b0;
                        we_d    = i_d_we;
                        wdata_d = i_d_wdata;
                        // Misaligned data never reaches memory but still
                        // consumes this grant turn.
                        if (is_misaligned(i_d_addr[1:0])) begin
                            err_d   = 1'b1;
                            state_d = RESP;
                        end
                    end else begin
                        addr_d  = {i_if_addr[AW-1:2], 2'b00};
                        hsel_d  = i_if_addr[1];
                        we_d    = 1'b0;
                        wdata_d = 32'd0;
                    end
                end
            end
            BUSY: begin
                if (i_m_ready) begin
                    rdata_d = we_q ? 32'd0 : i_m_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wait_q == WAIT_LAST) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            wait_q  <= 8'd0;
            last_q  <= REQ_D;
            gnt_q   <= REQ_IF;
            addr_q  <= '0;
            hsel_q  <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            hsel_q  <= hsel_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory-side outputs are only driven during an access so the port is
    // quiet in IDLE/RESP.
    assign busy      = (state_q == BUSY);
    assign o_m_req   = busy;
    assign o_m_we    = busy & we_q;
    assign o_m_addr  = busy ? addr_q : '0;
    assign o_m_wdata = busy ? wdata_q : 32'd0;

    assign if_ack = (state_q == RESP) && (gnt_q == REQ_IF);
    assign d_ack  = (state_q == RESP) && (gnt_q == REQ_D);

    assign o_if_ack   = if_ack;
    assign o_if_rdata = if_ack ? (hsel_q ? rdata_q[31:16] : rdata_q[15:0]) : 16'd0;
    assign o_if_err   = if_ack & err_q;
    assign o_d_ack    = d_ack;
    assign o_d_rdata  = d_ack ? rdata_q : 32'd0;
    assign o_d_err    = d_ack & err_q;

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arb #(.AW(32), .TIMEOUT(TO)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_if_req   (if_req),
        .i_if_addr  (if_addr),
        .o_if_ack   (if_ack),
        .o_if_rdata (if_rdata),
        .o_if_err   (if_err),
        .i_d_req    (d_req),
        .i_d_we     (d_we),
        .i_d_addr   (d_addr),
        .i_d_wdata  (d_wdata),
        .o_d_ack    (d_ack),
        .o_d_rdata  (d_rdata),
        .o_d_err    (d_err),
        .o_m_req    (m_req),
        .o_m_we     (m_we),
        .o_m_addr   (m_addr),
        .o_m_wdata  (m_wdata),
        .i_m_ready  (m_ready),
        .i_m_rdata  (m_rdata)
    );

    always #5 clk = ~clk;

    // One directed vector: inputs held for a cycle, outputs expected after
    // the following rising edge. chk[0]: check addr/we, chk[1]: check wdata.
    // ack: bit0 fetch ack, bit1 data ack; rdata low 16 bits used for fetch.
    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        rdy;
        logic [31:0] mrd;
        logic        e_mreq;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic [1:0]  chk;
        logic [1:0]  ack;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t tbl [24];

    // Random-phase model state
    logic [31:0] mem [16];
    int          idle_at;
    logic        m_last;
    logic        a_valid;
    logic        a_who;
    logic        a_we;
    logic [31:0] a_maddr;
    logic [31:0] a_wdata;
    logic [31:0] a_rdata;
    logic        a_err;
    logic [31:0] a_mem_word;
    int          a_bs, a_be, a_rdy, a_ack;
    logic        if_act, d_act;
    int          if_gap, d_gap;
    logic [31:0] if_addr_v, d_addr_v, d_wdata_v;
    logic        d_we_v;
    logic        who;
    logic [31:0] addr;
    logic [3:0]  word;
    int          dly;
    logic        exp_busy, exp_ackc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic e_mreq, input logic e_mwe,
                           input logic [31:0] e_maddr, input logic [31:0] e_mwdata,
                           input logic [1:0] chk, input logic [1:0] ack,
                           input logic [31:0] e_rdata, input logic e_err);
        logic        ok;
        logic [15:0] x_if_rd;
        logic [31:0] x_d_rd;
        logic        x_if_err;
        logic        x_d_err;
        ok = (m_req === e_mreq);
        if (chk[0]) ok = ok && (m_addr === e_maddr) && (m_we === e_mwe);
        if (chk[1]) ok = ok && (m_wdata === e_mwdata);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s mem-side @%0t: got req=%0b we=%0b addr=%h wdata=%h, want req=%0b we=%0b addr=%h wdata=%h (chk=%b)",
                     name, $time, m_req, m_we, m_addr, m_wdata, e_mreq, e_mwe, e_maddr, e_mwdata, chk);
        end
        x_if_rd  = ack[0] ? e_rdata[15:0] : 16'h0;
        x_if_err = ack[0] & e_err;
        x_d_rd   = ack[1] ? e_rdata : 32'h0;
        x_d_err  = ack[1] & e_err;
        ok = (if_ack === ack[0]) && (if_rdata === x_if_rd) && (if_err === x_if_err) &&
             (d_ack === ack[1]) && (d_rdata === x_d_rd) && (d_err === x_d_err);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s response @%0t: got if_ack=%0b if_rdata=%h if_err=%0b d_ack=%0b d_rdata=%h d_err=%0b, want if_ack=%0b if_rdata=%h if_err=%0b d_ack=%0b d_rdata=%h d_err=%0b",
                     name, $time, if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
                     ack[0], x_if_rd, x_if_err, ack[1], x_d_rd, x_d_err);
        end
    endtask

    task automatic idle_inputs();
        if_req  = 1'b0;
        if_addr = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        m_ready = 1'b0;
        m_rdata = 32'h0;
    endtask

    // Leaves the bench at the start of the first IDLE cycle after reset.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("reset", 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b00, 32'h0, 1'b0);
        end
        rst = 1'b0;
    endtask

    initial begin
        //            ir    ia          dr    dw    da          dwd           rdy   mrd             mreq  mwe   maddr       mwdata        chk    ack    rdata         err
        tbl[0]  = '{1'b1, 32'h102, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h100, 32'h0,        2'b01, 2'b00, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 32'h102, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 32'hBEEF1234, 1'b0, 1'b0, 32'h0,   32'h0,        2'b00, 2'b01, 32'h0000BEEF, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 32'h5A5A5A5A, 1'b0, 1'b0, 32'h0,   32'h0,        2'b00, 2'b00, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0,        1'b1, 1'b1, 32'h20,  32'hCAFEF00D, 2'b11, 2'b00, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0,   32'h0,        2'b00, 2'b10, 32'h0,        1'b0};
        tbl[5]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        2'b00, 2'b00, 32'h0,        1'b0};
        tbl[6]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h22, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        2'b00, 2'b10, 32'h0,        1'b1};
        tbl[7]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        2'b00, 2'b00, 32'h0,        1'b0};
        tbl[8]  = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h40,  32'h0,        2'b01, 2'b00, 32'h0,        1'b0};
        tbl[9]  = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h77777777, 1'b1, 1'b0, 32'h40,  32'h0,        2'b01, 2'b00, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h77777777, 1'b1, 1'b0, 32'h40,  32'h0,        2'b01, 2'b00, 32'h0,        1'b0};
        tbl[11] = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h77777777, 1'b1, 1'b0, 32'h40,  32'h0,        2'b01, 2'b00, 32'h0,        1'b0};
        tbl[12] = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h77777777, 1'b0, 1'b0, 32'h0,   32'h0,        2'b00, 2'b01, 32'h0,        1'b1};
        tbl[13] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 32'h66666666, 1'b0, 1'b0, 32'h0,   32'h0,        2'b00, 2'b00, 32'h0,        1'b0};
        tbl[14] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h84, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h84,  32'h0,        2'b11, 2'b00, 32'h0,        1'b0};
        tbl[15] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h84, 32'h0,        1'b0, 32'h99999999, 1'b1, 1'b0, 32'h84,  32'h0,        2'b11, 2'b00, 32'h0,        1'b0};
        tbl[16] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h84, 32'h0,        1'b1, 32'hA5A50F0F, 1'b0, 1'b0, 32'h0,   32'h0,        2'b00, 2'b10, 32'hA5A50F0F, 1'b0};
        tbl[17] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 32'h44444444, 1'b0, 1'b0, 32'h0,   32'h0,        2'b00, 2'b00, 32'h0,        1'b0};
        tbl[18] = '{1'b1, 32'h06,  1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h04,  32'h0,        2'b01, 2'b00, 32'h0,        1'b0};
        tbl[19] = '{1'b1, 32'h06,  1'b1, 1'b0, 32'h10, 32'h0,        1'b1, 32'h11112222, 1'b0, 1'b0, 32'h0,   32'h0,        2'b00, 2'b01, 32'h00001111, 1'b0};
        tbl[20] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        2'b00, 2'b00, 32'h0,        1'b0};
        tbl[21] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h10,  32'h0,        2'b11, 2'b00, 32'h0,        1'b0};
        tbl[22] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h10, 32'h0,        1'b1, 32'h33334444, 1'b0, 1'b0, 32'h0,   32'h0,        2'b00, 2'b10, 32'h33334444, 1'b0};
        tbl[23] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        2'b00, 2'b00, 32'h0,        1'b0};

        // ---------------- directed vectors ----------------
        do_reset();
        for (int i = 0; i < 24; i++) begin
            if_req  = tbl[i].ir;
            if_addr = tbl[i].ia;
            d_req   = tbl[i].dr;
            d_we    = tbl[i].dw;
            d_addr  = tbl[i].da;
            d_wdata = tbl[i].dwd;
            m_ready = tbl[i].rdy;
            m_rdata = tbl[i].mrd;
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].e_mreq, tbl[i].e_mwe, tbl[i].e_maddr,
                    tbl[i].e_mwdata, tbl[i].chk, tbl[i].ack, tbl[i].e_rdata, tbl[i].e_err);
            $display("[TB] vec %0d: if_req=%0b d_req=%0b m_req=%0b if_ack=%0b d_ack=%0b",
                     i, tbl[i].ir, tbl[i].dr, m_req, if_ack, d_ack);
        end

        // ---------------- round robin with both always requesting ----------------
        do_reset();
        if_req  = 1'b1;
        if_addr = 32'h10;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h20;
        m_ready = 1'b1;
        m_rdata = 32'h89ABCDEF;
        for (int c = 1; c <= 12; c++) begin
            int ph;
            int wi;
            step();
            ph = (c - 1) % 3;
            wi = ((c - 1) / 3) % 2;
            if (ph == 0)
                chk_out("rr_alt_busy", 1'b1, 1'b0, (wi != 0) ? 32'h20 : 32'h10, 32'h0,
                        2'b01, 2'b00, 32'h0, 1'b0);
            else if (ph == 1)
                chk_out("rr_alt_ack", 1'b0, 1'b0, 32'h0, 32'h0, 2'b00,
                        (wi != 0) ? 2'b10 : 2'b01,
                        (wi != 0) ? 32'h89ABCDEF : 32'h0000CDEF, 1'b0);
            else
                chk_out("rr_alt_idle", 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 1'b0);
            $display("[TB] rr cycle %0d: m_req=%0b if_ack=%0b d_ack=%0b", c, m_req, if_ack, d_ack);
        end
        idle_inputs();
        step();

        // ---------------- reset during BUSY, then re-issue ----------------
        do_reset();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h30;
        d_wdata = 32'h0BADBEEF;
        step();
        chk_out("rst_busy_pre", 1'b1, 1'b1, 32'h30, 32'h0BADBEEF, 2'b11, 2'b00, 32'h0, 1'b0);
        rst = 1'b1;
        step();
        chk_out("rst_busy_abandon", 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b00, 32'h0, 1'b0);
        rst = 1'b0;
        step();
        chk_out("rst_busy_reissue", 1'b1, 1'b1, 32'h30, 32'h0BADBEEF, 2'b11, 2'b00, 32'h0, 1'b0);
        m_ready = 1'b1;
        m_rdata = 32'hFFFFFFFF;
        step();
        chk_out("rst_busy_ack", 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b10, 32'h0, 1'b0);
        idle_inputs();
        step();
        chk_out("rst_busy_after", 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 1'b0);
        $display("[TB] reset-in-busy sequence done");

        // ---------------- randomized traffic vs transaction model ----------------
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        idle_at = 0;
        m_last  = 1'b1;
        a_valid = 1'b0;
        a_who = 1'b0; a_we = 1'b0; a_maddr = 32'h0; a_wdata = 32'h0;
        a_rdata = 32'h0; a_err = 1'b0; a_mem_word = 32'h0;
        a_bs = 0; a_be = -1; a_rdy = -1; a_ack = -1;
        if_act = 1'b0; d_act = 1'b0; if_gap = 0; d_gap = 1;
        if_addr_v = 32'h0; d_addr_v = 32'h0; d_wdata_v = 32'h0; d_we_v = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            exp_busy = a_valid && (t >= a_bs) && (t <= a_be);
            exp_ackc = a_valid && (t == a_ack);
            chk_out("rand", exp_busy, a_we, a_maddr, a_wdata,
                    exp_busy ? (a_who ? 2'b11 : 2'b01) : 2'b00,
                    exp_ackc ? (a_who ? 2'b10 : 2'b01) : 2'b00, a_rdata, a_err);
            if (exp_ackc) begin
                $display("[TB] rand txn t=%0d %s addr=%h we=%0b err=%0b rdata=%h",
                         t, a_who ? "D " : "IF", a_maddr, a_we, a_err, a_rdata);
                if (a_who) begin d_act = 1'b0; d_gap = $urandom_range(0, 2); end
                else begin if_act = 1'b0; if_gap = $urandom_range(0, 2); end
            end

            // requesters
            if (!if_act) begin
                if (if_gap == 0) begin
                    if_act    = 1'b1;
                    if_addr_v = {26'h0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0};
                end else if_gap--;
            end
            if (!d_act) begin
                if (d_gap == 0) begin
                    d_act     = 1'b1;
                    d_addr_v  = {26'h0, 4'($urandom_range(0, 15)),
                                 ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
                    d_we_v    = 1'($urandom_range(0, 1));
                    d_wdata_v = $urandom;
                end else d_gap--;
            end
            if_req  = if_act;
            if_addr = if_addr_v;
            d_req   = d_act;
            d_we    = d_we_v;
            d_addr  = d_addr_v;
            d_wdata = d_wdata_v;

            // memory responder: ready only on the scheduled cycle while busy,
            // occasional stray ready when no access is in progress
            if (a_valid && (t == a_rdy)) begin
                m_ready = 1'b1;
                m_rdata = a_mem_word;
            end else begin
                m_ready = !exp_busy && ($urandom_range(0, 4) == 0);
                m_rdata = $urandom;
            end

            // grant decision when the arbiter is idle
            if ((t >= idle_at) && (if_act || d_act)) begin
                who     = (if_act && d_act) ? ~m_last : d_act;
                m_last  = who;
                a_valid = 1'b1;
                a_who   = who;
                if (who) begin
                    addr = d_addr_v; a_we = d_we_v; a_wdata = d_wdata_v;
                end else begin
                    addr = if_addr_v; a_we = 1'b0; a_wdata = 32'h0;
                end
                a_maddr    = {addr[31:2], 2'b00};
                word       = addr[5:2];
                a_mem_word = mem[word];
                a_bs       = t + 1;
                if (who && (addr[1:0] != 2'b00)) begin
                    a_be = t; a_rdy = -1; a_ack = t + 1; idle_at = t + 2;
                    a_err = 1'b1; a_rdata = 32'h0;
                end else begin
                    dly = $urandom_range(0, 5);
                    if (dly < TO) begin
                        a_be = t + 1 + dly; a_rdy = t + 1 + dly;
                        a_ack = t + 2 + dly; idle_at = t + 3 + dly;
                        a_err = 1'b0;
                        if (!who)
                            a_rdata = addr[1] ? {16'h0, a_mem_word[31:16]} : {16'h0, a_mem_word[15:0]};
                        else if (a_we) begin
                            a_rdata   = 32'h0;
                            mem[word] = a_wdata;
                        end else
                            a_rdata = a_mem_word;
                    end else begin
                        a_be = t + TO; a_rdy = -1; a_ack = t + TO + 1; idle_at = t + TO + 2;
                        a_err = 1'b1; a_rdata = 32'h0;
                    end
                end
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
